fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage that feeds the control unit and decode path of the single-cycle core. Owns the program counter, issues word requests to instruction memory over a req/ready handshake, holds each fetched instruction stable until the core signals retirement, then computes the next PC from the control unit's PC-source select and the branch outcome. Exposes the opcode, funct3 and funct7 fields that the control unit consumes directly.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address, always equal to pc
- imem_ready  in  1  memory has valid imem_rdata this cycle
- imem_rdata  in  32  fetched instruction word
- cu_PC_src  in  2  PC source for the held instruction: 00 seq, 01 branch, 10 jal, 11 jalr
- branch_taken  in  1  branch condition true (cu_branch qualified by ALU result)
- br_imm  in  32  sign-extended B/J immediate
- jalr_base  in  32  rs1 + imm from the ALU
- retire  in  1  core finishes the held instruction this cycle
- inst  out  32  held instruction
- inst_valid  out  1  inst is valid for execution
- pc  out  32  address of inst
- pc_plus4  out  32  pc + 4, the link value for jal/jalr
- opcode / funct3 / funct7  out  7 / 3 / 7  inst[6:0], inst[14:12], inst[31:25]
- fetch_fault  out  1  sticky misaligned-target fault

## Operation
- FSM states are IDLE, REQ, HOLD and FAULT.
- **IDLE**: entered on reset. imem_req = 0. Moves unconditionally to REQ on the next edge.
- **REQ**: imem_req = 1 and imem_addr = pc, both held stable until imem_ready is sampled high.
  - On the edge with imem_ready = 1, inst <= imem_rdata and the FSM moves to HOLD.
  - imem_ready in the same cycle that req rises is legal (zero-wait).
- **HOLD**: inst_valid = 1 and imem_req = 0. On an edge with retire = 1:
  - pc <= next_pc.
  - Next state is FAULT if next_pc[1:0] != 0, otherwise REQ.
- **FAULT**: fetch_fault = 1, imem_req = 0, inst_valid = 0. pc shows the offending target. The only exit is reset.
- next_pc is selected by cu_PC_src:
  - 00: pc+4.
  - 01: pc+br_imm if branch_taken, else pc+4.
  - 10: pc+br_imm.
  - 11: {jalr_base[31:1], 1'b0}.
- All PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 without fault.
- retire is ignored outside HOLD. imem_ready is ignored outside REQ.
- cu_PC_src, branch_taken, br_imm and jalr_base are sampled only on the retiring edge.
- Reset values: pc = RESET_PC, inst = 32'h0000_0013 (NOP, so the control unit sees a benign opcode), inst_valid = 0, imem_req = 0, fetch_fault = 0, state = IDLE.

## Timing
- imem_req, inst_valid and fetch_fault are decoded from state only. No input reaches these outputs combinationally.
- opcode, funct3, funct7 and pc_plus4 are combinational from the inst and pc registers.
- Latency with a zero-wait memory:
  - reset release -> IDLE 1 cycle -> REQ 1 cycle -> inst_valid high from the 3rd cycle.
  - Steady state is 2 cycles per instruction when retire is asserted in the first HOLD cycle.
- Each cycle of imem_ready low extends REQ by one cycle. Each cycle of retire low extends HOLD by one cycle.
- rst_n assertion at any time, including mid-REQ, clears all state asynchronously; imem_req drops in the same cycle. Release is synchronised by the IDLE cycle.
- A response arriving after reset is not captured.

## Structure
- Shared package `fetch_pkg`:
  - PC-source encodings: PC_SEQ = 00, PC_BR = 01, PC_JAL = 10, PC_JALR = 11.
  - FSM state enum.
  - NOP_INST = 32'h0000_0013.
  - RESET_PC default.
- One sub-module, `npc_gen`: the purely combinational next_pc mux, adders and misalignment check. The FSM and registers stay in fetch_unit.

## Test plan
- Reset, zero-wait memory, retire every HOLD cycle with cu_PC_src = 00 -> imem_addr sequence 0x0, 0x4, 0x8. inst_valid high on alternate cycles starting from the 3rd cycle after release.
- imem_ready low for 3 cycles in REQ -> imem_addr is stable for 4 cycles and inst_valid stays low. inst equals imem_rdata from the ready cycle.
- PC = 0x100, cu_PC_src = 01:
  - branch_taken = 1, br_imm = -8 -> next pc 0xF8.
  - branch_taken = 0 -> next pc 0x104.
  - cu_PC_src = 10, br_imm = 0x20 -> next pc 0x120.
- cu_PC_src = 11, jalr_base = 0x203 -> pc 0x202, then FAULT: fetch_fault = 1, imem_req = 0. Holds until rst_n pulse, then pc = RESET_PC.
- pc = 0xFFFF_FFFC, cu_PC_src = 00 -> pc wraps to 0x0 with no fault. retire pulsed during REQ has no effect.
- rst_n asserted mid-REQ while imem_ready = 1 -> imem_req is 0 in the same cycle, inst = 0x0000_0013, opcode = 7'b0010011.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction fetch stage: PC-source selects,
// FSM states, the reset instruction and the default reset PC.
package fetch_pkg;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JAL  = 2'b10;
  localparam logic [1:0] PC_JALR = 2'b11;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/npc_gen.sv
// Combinational next-PC generation: sequential/branch/jal/jalr select,
// 32-bit modulo adders and the misaligned-target flag.
module npc_gen
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] br_imm,
  input  logic [31:0] jalr_base,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] br_target;

  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc + br_imm;

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PC_SEQ:  next_pc = pc_plus4;
      PC_BR:   next_pc = branch_taken ? br_target : pc_plus4;
      PC_JAL:  next_pc = br_target;
      PC_JALR: next_pc = jalr_base & ~32'd1;
      default: next_pc = pc_plus4;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words over req/ready,
// holds each instruction until retire, then advances to the selected next PC.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | one cycle after reset release, no request
// ST_REQ   | imem_req high at pc, waiting for imem_ready
// ST_HOLD  | inst valid for the core, waiting for retire
// ST_FAULT | misaligned target taken, sticky until reset
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  cu_PC_src,
  input  logic        branch_taken,
  input  logic [31:0] br_imm,
  input  logic [31:0] jalr_base,
  input  logic        retire,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        fetch_fault
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  inst_q;
  logic         req_q;
  logic         valid_q;
  logic         fault_q;
  logic [31:0]  pc_d;
  logic         misaligned;

  npc_gen u_npc_gen (
    .pc           (pc_q),
    .pc_src       (cu_PC_src),
    .branch_taken (branch_taken),
    .br_imm       (br_imm),
    .jalr_base    (jalr_base),
    .pc_plus4     (pc_plus4),
    .next_pc      (pc_d),
    .misaligned   (misaligned)
  );

  // Outputs are registered alongside the state so no input reaches them combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_REQ;
          req_q   <= 1'b1;
        end
        ST_REQ: begin
          if (imem_ready) begin
            inst_q  <= imem_rdata;
            state_q <= ST_HOLD;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (retire) begin
            pc_q    <= pc_d;
            valid_q <= 1'b0;
            if (misaligned) begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q <= ST_REQ;
              req_q   <= 1'b1;
            end
          end
        end
        ST_FAULT: begin
          state_q <= ST_FAULT;
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign inst        = inst_q;
  assign inst_valid  = valid_q;
  assign fetch_fault = fault_q;
  assign opcode      = inst_q[6:0];
  assign funct3      = inst_q[14:12];
  assign funct7      = inst_q[31:25];

endmodule
